// File: rtl/br_redirect_ctrl_if.sv
// Branch-resolution bundle: EXE result in, fetch redirect / misalign exception out,
// plus trap override and statistics. master = redirect controller, slave = pipeline side.
interface br_redirect_ctrl_if #(
    parameter int PC_SZ  = 32,
    parameter int CNT_SZ = 16
);
    logic              exe_valid;
    logic [PC_SZ-1:0]  exe_br_pc;
    logic [PC_SZ-1:0]  exe_pred_pc;
    logic              exe_mis;
    logic              exe_ack;
    logic              trap_in;
    logic              fet_redir_valid;
    logic [PC_SZ-1:0]  fet_redir_pc;
    logic              fet_redir_ready;
    logic              flush;
    logic              exc_valid;
    logic [PC_SZ-1:0]  exc_tval;
    logic              exc_ack;
    logic [CNT_SZ-1:0] br_cnt;
    logic [CNT_SZ-1:0] mispred_cnt;

    modport master (
        input  exe_valid, exe_br_pc, exe_pred_pc, exe_mis, trap_in,
        input  fet_redir_ready, exc_ack,
        output exe_ack, fet_redir_valid, fet_redir_pc, flush,
        output exc_valid, exc_tval, br_cnt, mispred_cnt
    );

    modport slave (
        output exe_valid, exe_br_pc, exe_pred_pc, exe_mis, trap_in,
        output fet_redir_ready, exc_ack,
        input  exe_ack, fet_redir_valid, fet_redir_pc, flush,
        input  exc_valid, exc_tval, br_cnt, mispred_cnt
    );
endinterface

// File: rtl/br_redirect_ctrl.sv
// Branch redirect controller: turns resolved EXE branches into a fetch redirect or a
// misaligned-target exception, with a one-cycle IF/ID flush and saturating statistics.
module br_redirect_ctrl #(
    parameter int PC_SZ  = 32,
    parameter int CNT_SZ = 16
) (
    input logic                clk_in,
    input logic                reset_in,
    br_redirect_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, REDIR, EXC} state_t;

    state_t            state_q, state_d;
    logic              redir_valid_q, redir_valid_d;
    logic [PC_SZ-1:0]  redir_pc_q, redir_pc_d;
    logic              flush_q, flush_d;
    logic              exc_valid_q, exc_valid_d;
    logic [PC_SZ-1:0]  exc_tval_q, exc_tval_d;
    logic [CNT_SZ-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_SZ-1:0] mispred_cnt_q, mispred_cnt_d;
    logic              ack;
    logic              accept;

    function automatic logic [CNT_SZ-1:0] sat_inc(input logic [CNT_SZ-1:0] v);
        if (&v)
            return v;
        return v + CNT_SZ'(1);
    endfunction

    // Only IDLE takes new work, so an EXE result landing in the handshake cycle waits.
    assign ack    = (state_q == IDLE) && !bus.trap_in;
    assign accept = bus.exe_valid && ack;

    always_comb begin
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        flush_d       = 1'b0;
        exc_valid_d   = exc_valid_q;
        exc_tval_d    = exc_tval_q;
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (bus.trap_in) begin
            state_d       = IDLE;
            redir_valid_d = 1'b0;
            exc_valid_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        br_cnt_d = sat_inc(br_cnt_q);
                        // A misaligned target faults even if it was also mispredicted.
                        if (bus.exe_mis) begin
                            state_d     = EXC;
                            exc_valid_d = 1'b1;
                            exc_tval_d  = bus.exe_br_pc;
                            flush_d     = 1'b1;
                        end else if (bus.exe_br_pc != bus.exe_pred_pc) begin
                            state_d       = REDIR;
                            redir_valid_d = 1'b1;
                            redir_pc_d    = bus.exe_br_pc;
                            flush_d       = 1'b1;
                            mispred_cnt_d = sat_inc(mispred_cnt_q);
                        end
                    end
                end
                REDIR: begin
                    if (bus.fet_redir_ready) begin
                        state_d       = IDLE;
                        redir_valid_d = 1'b0;
                    end
                end
                EXC: begin
                    if (bus.exc_ack) begin
                        state_d     = IDLE;
                        exc_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d       = IDLE;
                    redir_valid_d = 1'b0;
                    exc_valid_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            exc_valid_q   <= 1'b0;
            exc_tval_q    <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            exc_valid_q   <= exc_valid_d;
            exc_tval_q    <= exc_tval_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.exe_ack         = ack;
    assign bus.fet_redir_valid = redir_valid_q;
    assign bus.fet_redir_pc    = redir_pc_q;
    assign bus.flush           = flush_q;
    assign bus.exc_valid       = exc_valid_q;
    assign bus.exc_tval        = exc_tval_q;
    assign bus.br_cnt          = br_cnt_q;
    assign bus.mispred_cnt     = mispred_cnt_q;

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Bench for br_redirect_ctrl: directed scenarios plus random traffic against a
// transaction-level model; a narrow-counter twin shares the stimulus to reach saturation.
module tb_br_redirect_ctrl;

    logic clk_in = 1'b0;
    logic reset_in;
    always #5 clk_in = ~clk_in;

    br_redirect_ctrl_if #(.PC_SZ(32), .CNT_SZ(16)) mif ();
    br_redirect_ctrl_if #(.PC_SZ(32), .CNT_SZ(4))  sif ();

    assign sif.exe_valid       = mif.exe_valid;
    assign sif.exe_br_pc       = mif.exe_br_pc;
    assign sif.exe_pred_pc     = mif.exe_pred_pc;
    assign sif.exe_mis         = mif.exe_mis;
    assign sif.trap_in         = mif.trap_in;
    assign sif.fet_redir_ready = mif.fet_redir_ready;
    assign sif.exc_ack         = mif.exc_ack;

    br_redirect_ctrl #(.PC_SZ(32), .CNT_SZ(16)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (mif.master)
    );

    br_redirect_ctrl #(.PC_SZ(32), .CNT_SZ(4)) dut_sat (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (sif.master)
    );

    int total = 0;
    int bad   = 0;

    // Model: what is outstanding (0 nothing, 1 redirect, 2 exception) and plain counts.
    int          m_kind = 0;
    int          m_br   = 0;
    int          m_mp   = 0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_tval = '0;
    logic        m_flush = 1'b0;

    function automatic logic [15:0] lim16(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    function automatic logic [3:0] lim4(input int n);
        return (n > 15) ? 4'hF : 4'(n);
    endfunction

    function automatic logic [98:0] obs_vec();
        return {mif.fet_redir_valid, mif.fet_redir_pc, mif.flush, mif.exc_valid,
                mif.exc_tval, mif.br_cnt, mif.mispred_cnt};
    endfunction

    function automatic logic [98:0] exp_vec();
        return {(m_kind == 1), m_pc, m_flush, (m_kind == 2), m_tval, lim16(m_br), lim16(m_mp)};
    endfunction

    task automatic model_reset();
        m_kind = 0; m_br = 0; m_mp = 0; m_pc = '0; m_tval = '0; m_flush = 1'b0;
    endtask

    // Drive one cycle starting just after a rising edge; returns the exe_ack seen and the
    // one the model wants, then advances the model across the edge.
    task automatic cyc(input logic v, input logic [31:0] bpc, input logic [31:0] ppc,
                       input logic mis, input logic rdy, input logic ack, input logic trap,
                       output logic ack_seen, output logic ack_exp);
        mif.exe_valid = v; mif.exe_br_pc = bpc; mif.exe_pred_pc = ppc; mif.exe_mis = mis;
        mif.fet_redir_ready = rdy; mif.exc_ack = ack; mif.trap_in = trap;
        #2;
        ack_seen = mif.exe_ack;
        ack_exp  = (m_kind == 0) && !trap;
        m_flush  = 1'b0;
        if (trap) m_kind = 0;
        else if (m_kind == 1) begin if (rdy) m_kind = 0; end
        else if (m_kind == 2) begin if (ack) m_kind = 0; end
        else if (v) begin
            m_br++;
            if (mis) begin m_kind = 2; m_tval = bpc; m_flush = 1'b1; end
            else if (bpc != ppc) begin m_kind = 1; m_pc = bpc; m_mp++; m_flush = 1'b1; end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        mif.exe_valid = 0; mif.exe_br_pc = '0; mif.exe_pred_pc = '0; mif.exe_mis = 0;
        mif.fet_redir_ready = 0; mif.exc_ack = 0; mif.trap_in = 0;
        model_reset();
        #3;
        total++;
        if (obs_vec() !== '0) begin
            bad++; $display("FAIL reset_outputs got %h want 0", obs_vec());
        end
        total++;
        if (mif.exe_ack !== 1'b1) begin
            bad++; $display("FAIL reset_ack_notrap got %b want 1", mif.exe_ack);
        end
        mif.trap_in = 1'b1;
        #1;
        total++;
        if (mif.exe_ack !== 1'b0) begin
            bad++; $display("FAIL reset_ack_trap got %b want 0", mif.exe_ack);
        end
        mif.trap_in = 1'b0;
        @(posedge clk_in); @(posedge clk_in); #1;
        reset_in = 1'b1;
    endtask

    task automatic test_correct_pred();
        logic a, e;
        cyc(1, 32'h100, 32'h100, 0, 0, 0, 0, a, e);
        total++;
        if (a !== 1'b1) begin bad++; $display("FAIL corr_ack got %b want 1", a); end
        total++;
        if ({mif.flush, mif.fet_redir_valid, mif.exc_valid, mif.br_cnt, mif.mispred_cnt}
            !== {3'b000, 16'd1, 16'd0}) begin
            bad++; $display("FAIL corr_state got fl=%b rv=%b ev=%b br=%0d mp=%0d want 0 0 0 1 0",
                            mif.flush, mif.fet_redir_valid, mif.exc_valid, mif.br_cnt, mif.mispred_cnt);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, a, e);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL corr_idle got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_mispredict_bp();
        logic a, e;
        int   held;
        held = 0;
        cyc(1, 32'h200, 32'h104, 0, 0, 0, 0, a, e);
        total++;
        if (mif.flush !== 1'b1 || mif.fet_redir_pc !== 32'h200) begin
            bad++; $display("FAIL mp_first got fl=%b pc=%h want 1 00000200", mif.flush, mif.fet_redir_pc);
        end
        if (mif.fet_redir_valid === 1'b1) held++;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, (i == 3), 0, 0, a, e);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL mp_cyc%0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (mif.fet_redir_valid === 1'b1 && mif.fet_redir_pc === 32'h200) held++;
        end
        total++;
        if (held != 4) begin bad++; $display("FAIL mp_hold got %0d cycles want 4", held); end
        total++;
        if (mif.mispred_cnt !== 16'd1 || mif.fet_redir_valid !== 1'b0) begin
            bad++; $display("FAIL mp_end got mp=%0d rv=%b want 1 0", mif.mispred_cnt, mif.fet_redir_valid);
        end
    endtask

    task automatic test_misaligned();
        logic a, e;
        logic [15:0] mp0, br0;
        mp0 = mif.mispred_cnt; br0 = mif.br_cnt;
        cyc(1, 32'h202, 32'h104, 1, 0, 0, 0, a, e);
        total++;
        if ({mif.exc_valid, mif.exc_tval, mif.flush, mif.fet_redir_valid} !== {1'b1, 32'h202, 1'b1, 1'b0}) begin
            bad++; $display("FAIL mis_first got ev=%b tv=%h fl=%b rv=%b want 1 00000202 1 0",
                            mif.exc_valid, mif.exc_tval, mif.flush, mif.fet_redir_valid);
        end
        total++;
        if (mif.br_cnt !== br0 + 16'd1 || mif.mispred_cnt !== mp0) begin
            bad++; $display("FAIL mis_cnt got br=%0d mp=%0d want %0d %0d", mif.br_cnt, mif.mispred_cnt, br0 + 1, mp0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h300, 32'h300, 0, 0, (i == 2), 0, a, e);
            total++;
            if (a !== 1'b0 || obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL mis_cyc%0d got ack=%b %h want 0 %h", i, a, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_trap_abort();
        logic a, e;
        logic [15:0] br0, mp0;
        cyc(1, 32'h400, 32'h108, 0, 0, 0, 0, a, e);
        br0 = mif.br_cnt; mp0 = mif.mispred_cnt;
        cyc(1, 32'h500, 32'h500, 0, 1, 0, 1, a, e);
        total++;
        if (a !== 1'b0 || mif.fet_redir_valid !== 1'b0 || mif.br_cnt !== br0 || mif.mispred_cnt !== mp0) begin
            bad++; $display("FAIL trap_redir got ack=%b rv=%b br=%0d mp=%0d want 0 0 %0d %0d",
                            a, mif.fet_redir_valid, mif.br_cnt, mif.mispred_cnt, br0, mp0);
        end
        cyc(1, 32'h602, 32'h602, 1, 0, 0, 0, a, e);
        cyc(0, 0, 0, 0, 0, 1, 1, a, e);
        total++;
        if (obs_vec() !== exp_vec() || mif.exc_valid !== 1'b0) begin
            bad++; $display("FAIL trap_exc got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic a, e;
        logic exp_acks [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cyc(1, (i == 0) ? 32'h700 : 32'h800, (i == 0) ? 32'h10c : 32'h800, 0, (i == 2), 0, 0, a, e);
            total++;
            if (a !== exp_acks[i] || obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL b2b_cyc%0d got ack=%b %h want %b %h", i, a, obs_vec(), exp_acks[i], exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic a, e, prev_flush;
        logic [31:0] bpc, ppc;
        prev_flush = mif.flush;
        for (int i = 0; i < 400; i++) begin
            bpc = $urandom & 32'hFFFF_FFFC;
            ppc = ($urandom_range(0, 1) == 0) ? bpc : ($urandom & 32'hFFFF_FFFC);
            cyc($urandom_range(0, 3) != 0, bpc, ppc, $urandom_range(0, 5) == 0,
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0, a, e);
            total++;
            if (a !== e || obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL rand_cyc%0d got ack=%b %h want %b %h", i, a, obs_vec(), e, exp_vec());
            end
            total++;
            if (sif.br_cnt !== lim4(m_br) || sif.mispred_cnt !== lim4(m_mp) || (prev_flush && mif.flush)) begin
                bad++; $display("FAIL rand_sat%0d got br=%0d mp=%0d fl2=%b want %0d %0d 0", i,
                                sif.br_cnt, sif.mispred_cnt, prev_flush && mif.flush, lim4(m_br), lim4(m_mp));
            end
            prev_flush = mif.flush;
        end
    endtask

    task automatic test_saturation();
        logic a, e;
        cyc(0, 0, 0, 0, 1, 1, 0, a, e);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'h1000 + 32'(i * 16), 32'h2000, 0, 0, 0, 0, a, e);
            cyc(0, 0, 0, 0, 1, 0, 0, a, e);
        end
        total++;
        if (sif.mispred_cnt !== 4'hF || sif.br_cnt !== 4'hF || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL sat_cnt got br=%0d mp=%0d %h want 15 15 %h",
                            sif.br_cnt, sif.mispred_cnt, obs_vec(), exp_vec());
        end
        cyc(1, 32'h3000, 32'h3004, 0, 0, 0, 0, a, e);
        total++;
        if (sif.mispred_cnt !== 4'hF || sif.fet_redir_valid !== 1'b1 || mif.fet_redir_valid !== 1'b1) begin
            bad++; $display("FAIL sat_hold got mp=%0d rv=%b want 15 1", sif.mispred_cnt, sif.fet_redir_valid);
        end
        #2;
        reset_in = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs_vec() !== '0 || {sif.fet_redir_valid, sif.br_cnt, sif.mispred_cnt} !== '0) begin
            bad++; $display("FAIL async_reset got %h want 0", obs_vec());
        end
        total++;
        if (mif.exe_ack !== 1'b1) begin
            bad++; $display("FAIL async_reset_ack got %b want 1", mif.exe_ack);
        end
        @(posedge clk_in); #1;
        reset_in = 1'b1;
    endtask

    initial begin
        test_reset();
        @(posedge clk_in); #1;
        test_correct_pred();
        test_mispredict_bp();
        test_misaligned();
        test_trap_abort();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/br_redirect_ctrl.md
BR_REDIRECT_CTRL -- requirements
Module: br_redirect_ctrl

Interface
REQ-001 SHALL have parameter PC_SZ, default 32: width of PC and target fields.
REQ-002 SHALL have parameter CNT_SZ, default 16: width of the statistics counters.
REQ-003 SHALL have port clk_in  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_in  input  1: reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port exe_valid  input  1: a branch-class instruction (Bxx, JAL, JALR, xRET) resolved in EXE this cycle.
REQ-006 SHALL have port exe_br_pc  input  PC_SZ: resolved next PC from the branch FU.
REQ-007 SHALL have port exe_pred_pc  input  PC_SZ: PC that fetch actually issued after this instruction.
REQ-008 SHALL have port exe_mis  input  1: resolved target is misaligned.
REQ-009 SHALL have port exe_ack  output  1: controller accepts the EXE result this cycle.
REQ-010 SHALL have port trap_in  input  1: CSR trap/interrupt redirect; overrides this block.
REQ-011 SHALL have port fet_redir_valid  output  1: redirect request to fetch.
REQ-012 SHALL have port fet_redir_pc  output  PC_SZ: redirect target.
REQ-013 SHALL have port fet_redir_ready  input  1: fetch accepts redirect.
REQ-014 SHALL have port flush  output  1: one-cycle flush of IF/ID stages.
REQ-015 SHALL have port exc_valid  output  1: instruction-address-misaligned exception request to CSR.
REQ-016 SHALL have port exc_tval  output  PC_SZ: faulting target for mtval.
REQ-017 SHALL have port exc_ack  input  1: CSR accepts exception.
REQ-018 SHALL have port br_cnt  output  CNT_SZ: count of accepted branch-class instructions.
REQ-019 SHALL have port mispred_cnt  output  CNT_SZ: count of accepted redirects (mispredicts, including xRET).

Function
REQ-020 SHALL implement FSM states IDLE, REDIR and EXC, all outputs except exe_ack registered.
REQ-021 SHALL drive exe_ack = (state==IDLE) & !trap_in, combinationally.
REQ-022 SHALL define accept = exe_valid & exe_ack; no input is sampled without accept.
REQ-023 On accept with exe_mis=1 SHALL enter EXC next cycle with exc_valid=1, exc_tval=exe_br_pc, flush=1 for that one cycle; exe_mis has priority over a mispredict.
REQ-024 On accept with exe_mis=0 and exe_br_pc!=exe_pred_pc SHALL enter REDIR next cycle with fet_redir_valid=1, fet_redir_pc=exe_br_pc, flush=1 for that one cycle, mispred_cnt+1.
REQ-025 On accept with exe_mis=0 and exe_br_pc==exe_pred_pc SHALL stay IDLE with no redirect, flush or exception.
REQ-026 SHALL increment br_cnt on every accept, including the misaligned case.
REQ-027 Both counters SHALL saturate at all ones and never wrap.
REQ-028 In REDIR, fet_redir_valid and fet_redir_pc SHALL hold stable until the cycle fet_redir_ready=1; next cycle state=IDLE, fet_redir_valid=0.
REQ-029 In EXC, exc_valid and exc_tval SHALL hold stable until the cycle exc_ack=1; next cycle state=IDLE, exc_valid=0.
REQ-030 An exe_valid arriving in the same cycle as fet_redir_ready or exc_ack SHALL not be accepted (exe_ack=0); it is accepted no earlier than the following cycle.
REQ-031 trap_in=1 in any state SHALL force IDLE next cycle, clear fet_redir_valid and exc_valid, suppress accept, and leave the counters unchanged.
REQ-032 trap_in SHALL take priority over a simultaneous fet_redir_ready or exc_ack.
REQ-033 flush SHALL never be asserted for two consecutive cycles.

Reset
REQ-034 While reset_in=0: state=IDLE, fet_redir_valid=0, fet_redir_pc=0, flush=0, exc_valid=0, exc_tval=0, br_cnt=0, mispred_cnt=0.
REQ-035 Reset asserted mid-REDIR or mid-EXC SHALL drop all requests immediately, without waiting for a clock edge.
REQ-036 exe_ack SHALL equal !trap_in while in reset.

Verification
REQ-037 Correct prediction: exe_valid=1, exe_br_pc=exe_pred_pc=0x100 -> no flush, no redirect, br_cnt=1, mispred_cnt=0.
REQ-038 Mispredict with backpressure: exe_br_pc=0x200, exe_pred_pc=0x104, fet_redir_ready low for 3 cycles -> flush for 1 cycle; fet_redir_valid=1, fet_redir_pc=0x200 held for 4 cycles; then IDLE, mispred_cnt=1.
REQ-039 Misaligned target: exe_mis=1, exe_br_pc=0x202 -> exc_valid=1, exc_tval=0x202 until exc_ack, flush pulse, no fet_redir_valid, br_cnt+1, mispred_cnt unchanged.
REQ-040 Trap abort: trap_in=1 while in REDIR, with fet_redir_ready=1 in the same cycle -> IDLE next cycle, fet_redir_valid=0, counters unchanged.
REQ-041 Back-to-back: exe_valid held high across a mispredict -> exe_ack=0 in REDIR and in the fet_redir_ready cycle; the second branch is accepted the cycle after that.
REQ-042 Saturation: preload mispred_cnt to 0xFFFF (CNT_SZ=16), then a mispredict -> mispred_cnt stays 0xFFFF; then async reset mid-REDIR -> all outputs 0 at once.
